// File: rtl/cnn_layer_scheduler.sv
// ============================================================================
// Module   : cnn_layer_scheduler
// Purpose  : Sequences NUM_LAYERS layer passes on the shared CNN datapath and
//            ping-pongs the feature-map buffers between passes.
//            Optional macro LAYER_WATCHDOG_EN adds a RUN-state timeout to ERROR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_layer_scheduler #(
    parameter int NUM_LAYERS     = 2,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             layer_done,
    output logic             layer_start,
    output logic [IDX_W-1:0] layer_idx,
    output logic             buf_sel,
    output logic             buf_swap,
    output logic             busy,
    output logic             all_done,
    output logic             error
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LAUNCH = 3'd1;
    localparam logic [2:0] c_S_RUN    = 3'd2;
    localparam logic [2:0] c_S_SWAP   = 3'd3;
    localparam logic [2:0] c_S_FINISH = 3'd4;
    localparam logic [2:0] c_S_ERROR  = 3'd5;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    generate
        if (NUM_LAYERS < 1 || (2 ** IDX_W) < NUM_LAYERS || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("cnn_layer_scheduler: illegal parameter combination");
        end
    endgenerate

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             w_restart;
    logic             w_advance;
    logic [IDX_W-1:0] r_layer_idx;
    logic             r_buf_sel;
    logic             w_timeout;

`ifdef LAYER_WATCHDOG_EN
    localparam int c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    // RUN is only ever entered from LAUNCH, so clearing there clears on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_S_LAUNCH) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_S_RUN && !layer_done && r_wd_cnt != c_WD_LIMIT) begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end

    assign w_timeout = (r_wd_cnt == c_WD_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_LAUNCH;
                    w_restart   = 1'b1;
                end
            end
            c_S_LAUNCH: begin
                if (abort) begin
                    w_state_nxt = c_S_IDLE;
                    w_restart   = 1'b1;
                end else begin
                    w_state_nxt = c_S_RUN;
                end
            end
            c_S_RUN: begin
                // abort beats done, done beats the watchdog
                if (abort) begin
                    w_state_nxt = c_S_IDLE;
                    w_restart   = 1'b1;
                end else if (layer_done) begin
                    w_state_nxt = (r_layer_idx == c_LAST_IDX) ? c_S_FINISH : c_S_SWAP;
                end else if (w_timeout) begin
                    w_state_nxt = c_S_ERROR;
                end
            end
            c_S_SWAP: begin
                if (abort) begin
                    w_state_nxt = c_S_IDLE;
                    w_restart   = 1'b1;
                end else begin
                    w_state_nxt = c_S_LAUNCH;
                    w_advance   = 1'b1;
                end
            end
            c_S_FINISH, c_S_ERROR: begin
                if (start) begin
                    w_state_nxt = c_S_LAUNCH;
                    w_restart   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_restart   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_layer_idx <= '0;
            r_buf_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_restart) begin
                r_layer_idx <= '0;
                r_buf_sel   <= 1'b0;
            end else if (w_advance) begin
                r_layer_idx <= r_layer_idx + IDX_W'(1);
                r_buf_sel   <= ~r_buf_sel;
            end
        end
    end

    assign layer_start = (r_state == c_S_LAUNCH);
    assign buf_swap    = (r_state == c_S_SWAP);
    assign busy        = (r_state == c_S_LAUNCH) || (r_state == c_S_RUN) || (r_state == c_S_SWAP);
    assign all_done    = (r_state == c_S_FINISH);
    assign error       = (r_state == c_S_ERROR);
    assign layer_idx   = r_layer_idx;
    assign buf_sel     = r_buf_sel;

endmodule

`default_nettype wire
